// File: rtl/ysyx_dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package ysyx_dmem_pkg;

   // Control FSM states of the responder.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Width of the latency down-counter; covers latencies 0..15.
   localparam int CNT_W = 4;

   // Byte address of word 0 unless the instance overrides it.
   localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

endpackage

// File: rtl/ysyx_dmem_array.sv
// Word-organised RAM: one port, per-byte write enables, combinational read.
module ysyx_dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           i_we,
   input  logic [3:0]                     i_be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
   input  logic [31:0]                    i_wdata,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   // Byte-masked write; contents are deliberately never reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
               r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read data follows the index in the same cycle.
   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ysyx_dmem_responder.sv
// Memory-side end of the load/store interface: accepts one request, waits a
// programmable number of cycles, performs the RAM access and then holds a
// registered response until the initiator takes it.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both 1. The sender keeps valid and its payload stable
// until that edge; ready never depends combinationally on valid.
module ysyx_dmem_responder
   import ysyx_dmem_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output state_t      o_dbg_state
);

   localparam int               AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0]      WIN_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam bit               ZERO_LAT  = (LATENCY == 0);
   localparam logic [CNT_W-1:0] CNT_LOAD  = ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;

   logic             r_wen;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wmask;

   logic             r_rsp_valid;
   logic [31:0]      r_rsp_rdata;
   logic             r_rsp_err;

   logic             w_accept;
   logic             w_exec;
   logic             w_acc_wen;
   logic [31:0]      w_acc_addr;
   logic [31:0]      w_acc_wdata;
   logic [3:0]       w_acc_wmask;
   logic [32:0]      w_offset;
   logic             w_in_range;
   logic [AW-1:0]    w_idx;
   logic             w_ram_we;
   logic [31:0]      w_ram_rdata;

   // Ready only in IDLE, and held low while reset is asserted.
   assign req_ready   = (r_state == IDLE) && rst_n;
   assign w_accept    = (r_state == IDLE) && req_valid;

   // With zero latency the access runs on the acceptance edge itself, so it
   // must use the live request rather than the not-yet-latched copy.
   assign w_exec      = (ZERO_LAT && w_accept) ||
                        ((r_state == WAIT) && (r_count == '0));
   assign w_acc_wen   = (r_state == IDLE) ? req_wen   : r_wen;
   assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
   assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
   assign w_acc_wmask = (r_state == IDLE) ? req_wmask : r_wmask;

   // 33-bit offset: an address below the base goes negative (bit 32 set) and
   // therefore compares larger than the window instead of wrapping into it.
   assign w_offset    = {1'b0, w_acc_addr} - {1'b0, ADDR_BASE};
   assign w_in_range  = (w_offset < WIN_BYTES);
   assign w_idx       = w_offset[AW+1:2];
   assign w_ram_we    = w_exec && w_acc_wen && w_in_range;

   ysyx_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_be    (w_acc_wmask),
      .i_idx   (w_idx),
      .i_wdata (w_acc_wdata),
      .o_rdata (w_ram_rdata)
   );

   // State and latency counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Next-state logic: IDLE -> WAIT (or RESP at zero latency) -> RESP -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      unique case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (ZERO_LAT) begin
                  w_state_nxt = RESP;
               end else begin
                  w_state_nxt = WAIT;
                  w_count_nxt = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (r_count == '0) begin
               w_state_nxt = RESP;
            end else begin
               w_count_nxt = r_count - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Capture the request payload on acceptance for the delayed access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else if (w_accept) begin
         r_wen   <= req_wen;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_wmask <= req_wmask;
      end
   end

   // Response registers: loaded when the access executes, held until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_exec) begin
         r_rsp_valid <= 1'b1;
         r_rsp_err   <= !w_in_range;
         r_rsp_rdata <= (w_in_range && !w_acc_wen) ? w_ram_rdata : '0;
      end else if (r_rsp_valid && rsp_ready) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end
   end

   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// Directed bench for the data-memory responder. Three instances cover
// LATENCY = 2 (index 0), 0 (index 1) and 15 (index 2); a byte-level memory
// model produces the expected response of every accepted request.
module tb_ysyx_dmem_responder;
   import ysyx_dmem_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_wen   [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_wmask [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];
   state_t      dbg_state [3];

   ysyx_dmem_responder #(.LATENCY(2)) u_dut_l2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .o_dbg_state(dbg_state[0])
   );

   ysyx_dmem_responder #(.LATENCY(0)) u_dut_l0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .o_dbg_state(dbg_state[1])
   );

   ysyx_dmem_responder #(.LATENCY(15)) u_dut_l15 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
      .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_err(rsp_err[2]), .o_dbg_state(dbg_state[2])
   );

   // ---------------- scoreboard / model ----------------
   logic [32:0] exp_q [$];          // {err, rdata}
   logic [31:0] mdl [3][1024];
   int          errors = 0;
   int          checks = 0;
   int          acc_edge = 0;
   int          hs_edge  = 0;
   int          prev_acc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return ({32'h0, a} >= 64'h0000_0000_8000_0000) &&
             ({32'h0, a} <  64'h0000_0000_8000_1000);
   endfunction

   task automatic model_apply(input int k, input bit wen, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] wm,
                              output logic [32:0] e);
      int idx;
      if (!in_win(a)) begin
         e = {1'b1, 32'h0};
      end else begin
         idx = int'((a - 32'h8000_0000) >> 2);
         if (wen) begin
            for (int b = 0; b < 4; b++) begin
               if (wm[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
            end
            e = {1'b0, 32'h0};
         end else begin
            e = {1'b0, mdl[k][idx]};
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // mode: 0 = abandoned (no model update), 1 = model only, 2 = model + expect
   task automatic issue(input int k, input bit wen, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm, input int mode);
      int n;
      logic [32:0] e;
      req_valid[k] = 1'b1;
      req_wen[k]   = wen;
      req_addr[k]  = a;
      req_wdata[k] = wd;
      req_wmask[k] = wm;
      n = 0;
      while (req_ready[k] !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_accept", 64'(req_ready[k]), 64'd1);
      @(posedge clk); #1;
      acc_edge     = cyc;
      req_valid[k] = 1'b0;
      if (mode != 0) begin
         model_apply(k, wen, a, wd, wm, e);
         if (mode == 2) exp_q.push_back(e);
      end
   endtask

   task automatic collect(input int k, input int stall, input int exp_lat, input string tag);
      int n;
      logic [32:0] e;
      logic [31:0] d0;
      n = 0;
      while (rsp_valid[k] !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_valid"}, 64'(rsp_valid[k]), 64'd1);
      check({tag, "_lat"}, 64'(cyc - acc_edge + 1), 64'(exp_lat));
      d0 = rsp_rdata[k];
      repeat (stall) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, 64'(rsp_valid[k]), 64'd1);
         check({tag, "_hold_rdata"}, 64'(rsp_rdata[k]), 64'(d0));
         check({tag, "_hold_ready"}, 64'(req_ready[k]), 64'd0);
      end
      check({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
      e = exp_q.pop_front();
      check({tag, "_rdata"}, 64'(rsp_rdata[k]), 64'(e[31:0]));
      check({tag, "_err"}, 64'(rsp_err[k]), 64'(e[32]));
      rsp_ready[k] = 1'b1;
      @(posedge clk); #1;
      hs_edge      = cyc;
      rsp_ready[k] = 1'b0;
      check({tag, "_clr"}, 64'({rsp_valid[k], rsp_err[k], rsp_rdata[k]}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      for (int k = 0; k < 3; k++) begin
         req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0;   req_wmask[k] = '0; rsp_ready[k] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready[0]), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
      check("rst_rsp_err",   64'(rsp_err[0]),   64'd0);
      check("rst_state",     64'(dbg_state[0]), 64'(IDLE));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_req_ready", 64'(req_ready[0]), 64'd1);

      // full-word write then read
      issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 2); collect(0, 0, 3, "wr_full");
      issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2);         collect(0, 0, 3, "rd_full");

      // byte mask
      issue(0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 2); collect(0, 0, 3, "pre20");
      issue(0, 1'b1, 32'h8000_0020, 32'h00AB_0000, 4'b0100, 2); collect(0, 0, 3, "wr_b2");
      issue(0, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 2);         collect(0, 0, 3, "rd_b2");
      issue(0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 2); collect(0, 0, 3, "wr_m0");
      issue(0, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 2);         collect(0, 0, 3, "rd_m0");

      // out of range on both sides of the window
      issue(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 2);         collect(0, 0, 3, "rd_low");
      issue(0, 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'b1111, 2); collect(0, 0, 3, "pre_last");
      issue(0, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'b1111, 2); collect(0, 0, 3, "wr_high");
      issue(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'b0000, 2);         collect(0, 0, 3, "rd_last");

      // response backpressure with a second request held meanwhile
      issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 2);
      req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0020;
      req_wdata[0] = 32'h0; req_wmask[0] = 4'b0000;
      collect(0, 5, 3, "bp");
      issue(0, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 2);
      check("bp_second_accept", 64'(acc_edge), 64'(hs_edge + 1));
      collect(0, 0, 3, "bp2");

      // reset one cycle after a write is accepted (LATENCY=2): write lost
      issue(0, 1'b1, 32'h8000_0030, 32'h1111_1111, 4'b1111, 2); collect(0, 0, 3, "pre30");
      issue(0, 1'b1, 32'h8000_0030, 32'h2222_2222, 4'b1111, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst2_rsp_valid", 64'(rsp_valid[0]), 64'd0);
      check("rst2_req_ready", 64'(req_ready[0]), 64'd0);
      check("rst2_state",     64'(dbg_state[0]), 64'(IDLE));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(0, 1'b0, 32'h8000_0030, 32'h0, 4'b0000, 2);         collect(0, 0, 3, "rst2_rd");

      // same with LATENCY=0: write already executed on acceptance
      issue(1, 1'b1, 32'h8000_0030, 32'h1111_1111, 4'b1111, 2); collect(1, 0, 1, "pre30_l0");
      issue(1, 1'b1, 32'h8000_0030, 32'h3333_3333, 4'b1111, 1);
      check("rst0_valid_before", 64'(rsp_valid[1]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst0_rsp_valid", 64'(rsp_valid[1]), 64'd0);
      check("rst0_rsp_err",   64'(rsp_err[1]),   64'd0);
      check("rst0_req_ready", 64'(req_ready[1]), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1, 1'b0, 32'h8000_0030, 32'h0, 4'b0000, 2);         collect(1, 0, 1, "rst0_rd");

      // latency sweep: LATENCY=0 back-to-back reads
      issue(1, 1'b0, 32'h8000_0030, 32'h0, 4'b0000, 2);
      prev_acc = acc_edge;
      collect(1, 0, 1, "l0_a");
      issue(1, 1'b0, 32'h8000_0030, 32'h0, 4'b0000, 2);
      check("l0_period", 64'(acc_edge - prev_acc), 64'd2);
      collect(1, 0, 1, "l0_b");

      // latency sweep: LATENCY=15 back-to-back reads
      issue(2, 1'b1, 32'h8000_0040, 32'h5A5A_0F0F, 4'b1111, 2); collect(2, 0, 16, "l15_wr");
      issue(2, 1'b0, 32'h8000_0040, 32'h0, 4'b0000, 2);
      prev_acc = acc_edge;
      collect(2, 0, 16, "l15_a");
      issue(2, 1'b0, 32'h8000_0040, 32'h0, 4'b0000, 2);
      check("l15_period", 64'(acc_edge - prev_acc), 64'd17);
      collect(2, 0, 16, "l15_b");

      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_dmem_responder.md
# ysyx_dmem_responder

Word-organised data-memory responder: the memory-side end of the load/store request interface driven by the execute stage. It accepts one request at a time through a valid/ready handshake and performs byte-masked writes or aligned word reads on an internal RAM. It returns each result through a second valid/ready handshake after a programmable latency. It replaces direct DPI memory calls in simulation and lets the core be exercised against a real multi-cycle memory.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; bits [1:0] ignored for indexing.
- req_wdata  input  32  write data, already lane-aligned.
- req_wmask  input  4  byte enables for writes; bit i enables bits [8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  full aligned word for reads; 0 for writes and errors.
- rsp_err  output  1  access was outside the memory window.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, the block latches wen, addr, wdata and wmask. It goes to WAIT with count=LATENCY-1, or straight to RESP when LATENCY=0.
- WAIT: req_ready=0. The count decrements each cycle. When count==0, the access executes and the FSM moves to RESP on the same edge.
- Access execution:
  - Index = (addr-ADDR_BASE)>>2.
  - The access is in range iff ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS. Compare with 33-bit subtraction; no wrap.
  - In-range write: update only the bytes whose wmask bit is set. wmask=0 is a legal no-op.
  - In-range read: rsp_rdata = mem[index].
  - Out of range: no RAM change; rsp_err=1; rsp_rdata=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid&&rsp_ready. On that handshake the FSM returns to IDLE, and rsp_valid, rsp_rdata and rsp_err clear to 0 on the same edge.
- No response is ever dropped. The response must be accepted before the next request can be taken.
- Sign or zero extension and byte selection from addr[1:0] are the initiator's job.

## Timing
- Reset values: FSM=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, count=0.
- req_ready is forced to 0 while rst_n is low.
- RAM contents are not reset.
- Latency from the acceptance edge to the first cycle rsp_valid=1 is LATENCY+1 cycles.
- Back-to-back throughput is one transaction per LATENCY+2 cycles when rsp_ready is held high. The IDLE cycle after the response handshake is mandatory.
- req_ready is a function of state only, with no combinational path from req_valid.
- rsp_valid, rsp_rdata and rsp_err are registered.
- A write lands in RAM on the edge leaving WAIT, or the acceptance edge when LATENCY=0. A read issued afterwards observes the new data.
- If reset asserts mid-transaction, the transaction is abandoned and outputs drop immediately. A write not yet executed never occurs. An executed write persists.
- If req_valid is high while not in IDLE, the request is ignored and not latched; the initiator must hold it.

## Structure
- Package ysyx_dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - a width constant for the latency counter (4 bits);
  - the default ADDR_BASE.
- One sub-module, ysyx_dmem_array: a synchronous word RAM with a per-byte write enable, one read/write port and a registered-free combinational read. It is parameterised by DEPTH_WORDS.
- The control FSM, range check and response registers live in the top block.

## Test plan
- Full-word write then read: write 0x8000_0010 ← 0xDEADBEEF with wmask=1111, then read the same address → rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid first rises 3 cycles after each accept (LATENCY=2).
- Byte mask:
  - Preload the word with 0x11223344.
  - Write 0x00AB0000 with wmask=0100; read → 0x11AB3344.
  - Write wmask=0000; read → unchanged.
- Out of range:
  - Read 0x7FFF_FFFC → rsp_err=1, rsp_rdata=0.
  - Write ADDR_BASE+4*DEPTH_WORDS → rsp_err=1, and a subsequent read of the last word is unchanged.
- Response backpressure:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable, and req_ready=0 throughout.
  - A second req_valid held high is accepted only in the cycle after the handshake.
- Reset mid-operation: assert rst_n low one cycle after a write is accepted (LATENCY=2) → outputs clear at once, and a later read shows the old data. Repeat with LATENCY=0 → the write has taken effect.
- Latency sweep: LATENCY=0 and LATENCY=15, back-to-back reads with rsp_ready=1 → accept-to-valid spacing of 1 and 16 cycles, and a period of 2 and 17 cycles.
